// File: rtl/serial_pkg.sv
// Shared definitions for the serial_xfer transfer sequencer: state encoding and
// default parameter values.
package serial_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_TIMEOUT = 50000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_FETCH,
        ST_TX_SEND,
        ST_TX_GAP,
        ST_RX_WAIT,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/serial_timeout.sv
// RX idle cycle counter: counts enabled cycles, restarts on clear, and flags
// the cycle on which TIMEOUT cycles have elapsed.
module serial_timeout
    import serial_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt is 0 on the first enabled cycle, so this fires on the TIMEOUT-th one
    assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/serial_xfer.sv
// serial_xfer: sends tx_len host bytes to a UART, then collects rx_len bytes back.
// Optional RX idle timeout is built in when SERIAL_XFER_TIMEOUT_EN is defined.
module serial_xfer
    import serial_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  tx_len,
    input  logic [LEN_W-1:0]  rx_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_wr_strobe,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_rd_strobe
);
    state_t            state, state_n;
    logic [LEN_W-1:0]  tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
    logic [DATA_W-1:0] hold, hold_n, tx_data_n, out_data_n;
    logic              out_valid_n, tx_wr_n, rx_rd_n, busy_n, done_n;
    logic              rx_take, expired;

    assign in_ready = (state == ST_TX_FETCH);
    // The strobe register doubles as the one-cycle ignore after each read
    assign rx_take  = (state == ST_RX_WAIT) && rx_valid && !rx_rd_strobe;

    always_comb begin
        state_n     = state;
        tx_cnt_n    = tx_cnt;
        rx_cnt_n    = rx_cnt;
        hold_n      = hold;
        tx_data_n   = tx_data;
        out_data_n  = out_data;
        busy_n      = busy;
        out_valid_n = 1'b0;
        tx_wr_n     = 1'b0;
        rx_rd_n     = 1'b0;
        done_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_n   = 1'b1;
                    tx_cnt_n = tx_len;
                    rx_cnt_n = rx_len;
                    if (tx_len != '0)      state_n = ST_TX_FETCH;
                    else if (rx_len != '0) state_n = ST_RX_WAIT;
                    else                   state_n = ST_FINISH;
                end
            end
            ST_TX_FETCH: begin
                if (in_valid) begin
                    hold_n  = in_data;
                    state_n = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                if (!tx_busy) begin
                    tx_data_n = hold;
                    tx_wr_n   = 1'b1;
                    tx_cnt_n  = tx_cnt - LEN_W'(1);
                    state_n   = ST_TX_GAP;
                end
            end
            ST_TX_GAP: begin
                if (tx_cnt != '0)      state_n = ST_TX_FETCH;
                else if (rx_cnt != '0) state_n = ST_RX_WAIT;
                else                   state_n = ST_FINISH;
            end
            ST_RX_WAIT: begin
                if (rx_take) begin
                    out_data_n  = rx_data;
                    out_valid_n = 1'b1;
                    rx_rd_n     = 1'b1;
                    rx_cnt_n    = rx_cnt - LEN_W'(1);
                    if (rx_cnt == LEN_W'(1)) state_n = ST_FINISH;
                end else if (expired) begin
                    state_n = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            hold         <= '0;
            tx_data      <= '0;
            out_data     <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            tx_wr_strobe <= 1'b0;
            rx_rd_strobe <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            tx_cnt       <= tx_cnt_n;
            rx_cnt       <= rx_cnt_n;
            hold         <= hold_n;
            tx_data      <= tx_data_n;
            out_data     <= out_data_n;
            busy         <= busy_n;
            out_valid    <= out_valid_n;
            tx_wr_strobe <= tx_wr_n;
            rx_rd_strobe <= rx_rd_n;
            done         <= done_n;
        end
    end

`ifdef SERIAL_XFER_TIMEOUT_EN
    logic err_pend;

    serial_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == ST_RX_WAIT),
        .clear   ((state != ST_RX_WAIT) || rx_take),
        .expired (expired)
    );

    // The timeout is remembered until FINISH so the flag lines up with done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pend    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= (state == ST_FINISH) && err_pend;
            if (state == ST_FINISH) begin
                err_pend <= 1'b0;
            end else if ((state == ST_RX_WAIT) && expired && !rx_take) begin
                err_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign expired        = 1'b0;
    assign err_timeout    = 1'b0;
`endif

endmodule

// File: doc/serial_xfer.md
SERIAL_XFER -- requirements
Module: serial_xfer

Interface
REQ-001 Parameter DATA_W, default 8, UART character width in bits.
REQ-002 Parameter LEN_W, default 4, width of TX/RX byte counts; 0..2^LEN_W-1 bytes per transfer.
REQ-003 Parameter TIMEOUT, default 50000, RX idle timeout in clk cycles; used only when SERIAL_XFER_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
REQ-007 tx_len, rx_len  in  LEN_W each  bytes to send, then bytes to receive; sampled on accepted start.
REQ-008 in_data / in_valid / in_ready  in / in / out  DATA_W / 1 / 1  host TX byte stream; transfer on in_valid & in_ready.
REQ-009 out_data / out_valid  out  DATA_W / 1  received byte; out_valid is a one-cycle pulse per byte.
REQ-010 busy / done / err_timeout  out  1 each  transfer active / one-cycle completion pulse / timeout flag valid with done.
REQ-011 tx_data / tx_wr_strobe / tx_busy  out / out / in  DATA_W / 1 / 1  UART TX port.
REQ-012 rx_data / rx_valid / rx_rd_strobe  in / in / out  DATA_W / 1 / 1  UART RX port.

Function
REQ-013 States: IDLE, TX_FETCH, TX_SEND, TX_GAP, RX_WAIT, FINISH.
REQ-014 IDLE: busy=0; start=1 latches counts, sets busy next cycle; next state TX_FETCH if tx_len!=0, else RX_WAIT if rx_len!=0, else FINISH.
REQ-015 TX_FETCH: in_ready=1 (only state where asserted); on in_valid, byte registered, go TX_SEND.
REQ-016 TX_SEND: when tx_busy=0, drive tx_data, pulse tx_wr_strobe one cycle, decrement TX count, go TX_GAP.
REQ-017 TX_GAP: exactly one cycle, tx_busy ignored (UART busy latency); then TX_FETCH if TX count!=0, else RX_WAIT if rx count!=0, else FINISH.
REQ-018 RX_WAIT: on rx_valid, out_data<=rx_data, out_valid and rx_rd_strobe pulse one cycle, decrement RX count; at zero go FINISH.
REQ-019 RX_WAIT: rx_valid seen only once per byte; rx_valid held the cycle after rx_rd_strobe is not counted twice (one-cycle ignore after each read).
REQ-020 rx_valid outside RX_WAIT ignored; no strobe, byte left in UART.
REQ-021 FINISH: done=1 one cycle, busy=0 next cycle, return IDLE; start in FINISH ignored.
REQ-022 start while busy=1 ignored; counts not re-sampled.
REQ-023 Maximum lengths (2^LEN_W-1) complete without count wrap; count compares use full LEN_W width.

Reset
REQ-024 Asynchronous reset forces IDLE; busy, done, err_timeout, in_ready, out_valid, tx_wr_strobe, rx_rd_strobe = 0; tx_data, out_data, counts = 0.
REQ-025 Reset mid-transfer aborts immediately; no done pulse; held host/UART bytes discarded.

Configuration
REQ-026 With SERIAL_XFER_TIMEOUT_EN defined: cycle counter cleared on RX_WAIT entry and each byte received; reaching TIMEOUT in RX_WAIT goes FINISH with err_timeout=1 alongside done.
REQ-027 Without SERIAL_XFER_TIMEOUT_EN: no counter logic; RX_WAIT waits indefinitely; err_timeout tied 0.

Structure
REQ-028 Shared package serial_pkg holds state encoding enum and default DATA_W/LEN_W/TIMEOUT constants.
REQ-029 Single module; timeout counter is a sub-module serial_timeout (enable, clear, expired) instantiated only under SERIAL_XFER_TIMEOUT_EN.

Verification
REQ-030 tx_len=2, rx_len=1, in bytes 0x41,0x42, UART echoes 0x5A -> tx strobes carry 0x41 then 0x42; out_valid once with 0x5A; done one cycle; err_timeout=0.
REQ-031 tx_len=0, rx_len=3, rx bytes 0x01,0x02,0x03 with rx_valid held 2 cycles each -> exactly 3 out_valid pulses, 3 rx_rd_strobes, done once.
REQ-032 tx_len=1, tx_busy held high 20 cycles -> tx_wr_strobe only after tx_busy falls; start pulsed while busy ignored.
REQ-033 Timeout build, TIMEOUT=100, rx_len=1, no rx_valid -> done with err_timeout=1 at 100 cycles after RX_WAIT entry; non-timeout build stays busy.
REQ-034 tx_len=rx_len=0 -> done two cycles after start, no UART strobes.
REQ-035 Reset asserted mid-TX_SEND -> all outputs 0 asynchronously, no done; subsequent transfer completes normally.
